// File: rtl/cdiv_sched.sv
// cdiv_sched
// Round-robin front end for one shared, pipelined divider. Up to P_NUM_REQ
// requesters compete for the divider. At most one operation is accepted per
// cycle. Operands are registered onto the divider bus. Each operation carries
// a tag {vld, idx, dz, numerator} through a pipeline that matches the divider
// latency, so its result can be steered back to the requester that issued it.
//
// Handshake: a requester holds req_ih[i] high with stable operands until it
// sees gnt_oh[i]=1 in the same cycle. That cycle is the transfer. There is no
// result backpressure: res_vld_oh is a single-cycle pulse that the requester
// must always accept.
//
// Ports
//   clk_ir        clock
//   rst_il        asynchronous active-low reset
//   en_ih         grant enable (in-flight operations still drain when low)
//   req_ih        per-requester request
//   req_real_id   packed denominators, slot i = [i*W +: W]
//   req_im_id     packed numerators,   slot i = [i*W +: W]
//   gnt_oh        one-hot combinational grant
//   div_real_od   registered denominator to divider
//   div_im_od     registered numerator to divider
//   div_q_id      divider quotient (P_DIV_LAT cycles after div_*_od)
//   div_r_id      divider remainder
//   res_vld_oh    one-hot result valid pulse
//   res_q_od      result quotient
//   res_r_od      result remainder
//   res_dz_od     result was a divide-by-zero
//   busy_od       any operation in flight
module cdiv_sched #(
    parameter int P_DATA_W  = 32,
    parameter int P_NUM_REQ = 4,
    parameter int P_DIV_LAT = 1
) (
    input  logic                           clk_ir,
    input  logic                           rst_il,
    input  logic                           en_ih,
    input  logic [P_NUM_REQ-1:0]           req_ih,
    input  logic [P_NUM_REQ*P_DATA_W-1:0]  req_real_id,
    input  logic [P_NUM_REQ*P_DATA_W-1:0]  req_im_id,
    output logic [P_NUM_REQ-1:0]           gnt_oh,
    output logic [P_DATA_W-1:0]            div_real_od,
    output logic [P_DATA_W-1:0]            div_im_od,
    input  logic [P_DATA_W-1:0]            div_q_id,
    input  logic [P_DATA_W-1:0]            div_r_id,
    output logic [P_NUM_REQ-1:0]           res_vld_oh,
    output logic [P_DATA_W-1:0]            res_q_od,
    output logic [P_DATA_W-1:0]            res_r_od,
    output logic                           res_dz_od,
    output logic                           busy_od
);

    localparam int IW = $clog2(P_NUM_REQ);
    // One tag stage for the operand register plus one per divider stage, so
    // the last tag stage lines up with div_q_id/div_r_id.
    localparam int NS = P_DIV_LAT + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(P_NUM_REQ - 1);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [IW-1:0]       ptr_q, ptr_d;
    logic                found;
    logic [IW-1:0]       sel_idx;
    logic [IW-1:0]       cand_idx;
    int                  cand;
    logic                grant_w;
    logic [P_DATA_W-1:0] sel_real;
    logic [P_DATA_W-1:0] sel_im;

    // Search ptr, ptr+1, ... modulo P_NUM_REQ; first active request wins.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= P_NUM_REQ) begin
                cand = cand - P_NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (!found && req_ih[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    assign grant_w  = en_ih & found;
    assign sel_real = req_real_id[int'(sel_idx)*P_DATA_W +: P_DATA_W];
    assign sel_im   = req_im_id[int'(sel_idx)*P_DATA_W +: P_DATA_W];

    always_comb begin
        gnt_oh = '0;
        if (grant_w) begin
            gnt_oh[sel_idx] = 1'b1;
        end
    end

    // Pointer moves past the winner so it is served last next time round.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_w) begin
            ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + IW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Operand registers and tag pipeline
    // ------------------------------------------------------------------
    logic [P_DATA_W-1:0] div_real_q, div_im_q;
    logic                tag_vld_q [NS];
    logic [IW-1:0]       tag_idx_q [NS];
    logic                tag_dz_q  [NS];
    logic [P_DATA_W-1:0] tag_num_q [NS];

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            ptr_q      <= '0;
            div_real_q <= '0;
            div_im_q   <= '0;
            for (int s = 0; s < NS; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_idx_q[s] <= '0;
                tag_dz_q[s]  <= 1'b0;
                tag_num_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (grant_w) begin
                div_real_q <= sel_real;
                div_im_q   <= sel_im;
            end
            // Stage 0 always loads; a non-grant cycle simply inserts a bubble.
            tag_vld_q[0] <= grant_w;
            tag_idx_q[0] <= sel_idx;
            tag_dz_q[0]  <= (sel_real == '0);
            tag_num_q[0] <= sel_im;
            for (int s = 1; s < NS; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
                tag_dz_q[s]  <= tag_dz_q[s-1];
                tag_num_q[s] <= tag_num_q[s-1];
            end
        end
    end

    assign div_real_od = div_real_q;
    assign div_im_od   = div_im_q;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [P_NUM_REQ-1:0] res_vld_q, res_vld_d;
    logic [P_DATA_W-1:0]  res_q_q, res_q_d;
    logic [P_DATA_W-1:0]  res_r_q, res_r_d;
    logic                 res_dz_q, res_dz_d;

    always_comb begin
        res_vld_d = '0;
        res_q_d   = res_q_q;
        res_r_d   = res_r_q;
        res_dz_d  = res_dz_q;
        if (tag_vld_q[NS-1]) begin
            res_vld_d[tag_idx_q[NS-1]] = 1'b1;
            res_dz_d = tag_dz_q[NS-1];
            if (tag_dz_q[NS-1]) begin
                // Divider output is meaningless for a zero denominator.
                res_q_d = '1;
                res_r_d = tag_num_q[NS-1];
            end else begin
                res_q_d = div_q_id;
                res_r_d = div_r_id;
            end
        end
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            res_vld_q <= '0;
            res_q_q   <= '0;
            res_r_q   <= '0;
            res_dz_q  <= 1'b0;
        end else begin
            res_vld_q <= res_vld_d;
            res_q_q   <= res_q_d;
            res_r_q   <= res_r_d;
            res_dz_q  <= res_dz_d;
        end
    end

    assign res_vld_oh = res_vld_q;
    assign res_q_od   = res_q_q;
    assign res_r_od   = res_r_q;
    assign res_dz_od  = res_dz_q;

    always_comb begin
        busy_od = |res_vld_q;
        for (int s = 0; s < NS; s++) begin
            busy_od = busy_od | tag_vld_q[s];
        end
    end

endmodule

// File: tb/tb_cdiv_sched.sv
module tb_cdiv_sched;

    localparam int W = 32;
    localparam int N = 4;

    // ---------------- clock / reset / DUT ----------------
    logic           clk_ir = 1'b0;
    logic           rst_il = 1'b0;
    logic           en_ih = 1'b0;
    logic [N-1:0]   req_ih = '0;
    logic [N*W-1:0] req_real_id = '0;
    logic [N*W-1:0] req_im_id = '0;
    logic [N-1:0]   gnt_oh;
    logic [W-1:0]   div_real_od, div_im_od;
    logic [W-1:0]   div_q_id = '0;
    logic [W-1:0]   div_r_id = '0;
    logic [N-1:0]   res_vld_oh;
    logic [W-1:0]   res_q_od, res_r_od;
    logic           res_dz_od, busy_od;

    int total = 0;
    int bad = 0;

    always #5 clk_ir = ~clk_ir;

    cdiv_sched #(.P_DATA_W(W), .P_NUM_REQ(N), .P_DIV_LAT(1)) dut (
        .clk_ir(clk_ir), .rst_il(rst_il), .en_ih(en_ih), .req_ih(req_ih),
        .req_real_id(req_real_id), .req_im_id(req_im_id), .gnt_oh(gnt_oh),
        .div_real_od(div_real_od), .div_im_od(div_im_od),
        .div_q_id(div_q_id), .div_r_id(div_r_id), .res_vld_oh(res_vld_oh),
        .res_q_od(res_q_od), .res_r_od(res_r_od), .res_dz_od(res_dz_od),
        .busy_od(busy_od)
    );

    // Single-stage divider model; junk on zero denominator so the scheduler
    // must substitute its own divide-by-zero result.
    always @(posedge clk_ir) begin
        if (div_real_od != '0) begin
            div_q_id <= div_im_od / div_real_od;
            div_r_id <= div_im_od % div_real_od;
        end else begin
            div_q_id <= 32'hDEAD_BEEF;
            div_r_id <= 32'hDEAD_BEEF;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] re, input logic [W-1:0] im);
        req_real_id[i*W +: W] = re;
        req_im_id[i*W +: W]   = im;
    endtask

    // Default slot operands: real = i+2, im = 101+10*i
    // -> q/r: 50/1, 37/0, 30/1, 26/1
    logic [W-1:0] def_q [4] = '{32'd50, 32'd37, 32'd30, 32'd26};
    logic [W-1:0] def_r [4] = '{32'd1, 32'd0, 32'd1, 32'd1};

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < N; i++) set_slot(i, W'(i + 2), W'(101 + 10 * i));
        req_ih = '0;
        en_ih  = 1'b1;
        rst_il = 1'b0;
        #2;
        total++; if (gnt_oh !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt_oh); end
        total++; if (div_real_od !== 32'd0) begin bad++; $display("FAIL rst_div_real got=%h want=0", div_real_od); end
        total++; if (div_im_od !== 32'd0) begin bad++; $display("FAIL rst_div_im got=%h want=0", div_im_od); end
        total++; if (res_vld_oh !== 4'b0000) begin bad++; $display("FAIL rst_res_vld got=%b want=0000", res_vld_oh); end
        total++; if (res_q_od !== 32'd0) begin bad++; $display("FAIL rst_res_q got=%h want=0", res_q_od); end
        total++; if (res_r_od !== 32'd0) begin bad++; $display("FAIL rst_res_r got=%h want=0", res_r_od); end
        total++; if (res_dz_od !== 1'b0) begin bad++; $display("FAIL rst_res_dz got=%b want=0", res_dz_od); end
        total++; if (busy_od !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_od); end
        @(negedge clk_ir);
        rst_il = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] eg;
        int k;
        for (int c = 0; c < 11; c++) begin
            req_ih = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk_ir);
            eg = '0;
            if (c < 8) eg[c % 4] = 1'b1;
            total++; if (gnt_oh !== eg) begin bad++; $display("FAIL b2b_gnt c=%0d got=%b want=%b", c, gnt_oh, eg); end
            eg = '0;
            if (c >= 3) begin
                k = (c - 3) % 4;
                eg[k] = 1'b1;
                total++; if (res_q_od !== def_q[k]) begin bad++; $display("FAIL b2b_q c=%0d got=%0d want=%0d", c, res_q_od, def_q[k]); end
                total++; if (res_r_od !== def_r[k]) begin bad++; $display("FAIL b2b_r c=%0d got=%0d want=%0d", c, res_r_od, def_r[k]); end
                total++; if (res_dz_od !== 1'b0) begin bad++; $display("FAIL b2b_dz c=%0d got=%b want=0", c, res_dz_od); end
            end
            total++; if (res_vld_oh !== eg) begin bad++; $display("FAIL b2b_vld c=%0d got=%b want=%b", c, res_vld_oh, eg); end
            tick();
        end
    endtask

    task automatic test_single();
        set_slot(0, 32'd7, 32'd50);
        req_ih = 4'b0001;
        @(negedge clk_ir);
        total++; if (gnt_oh !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt_oh); end
        tick();
        req_ih = '0;
        @(negedge clk_ir);
        total++; if (div_real_od !== 32'd7) begin bad++; $display("FAIL single_div_real got=%0d want=7", div_real_od); end
        total++; if (div_im_od !== 32'd50) begin bad++; $display("FAIL single_div_im got=%0d want=50", div_im_od); end
        total++; if (busy_od !== 1'b1) begin bad++; $display("FAIL single_busy1 got=%b want=1", busy_od); end
        tick();
        @(negedge clk_ir);
        total++; if (res_vld_oh !== 4'b0000) begin bad++; $display("FAIL single_early got=%b want=0000", res_vld_oh); end
        tick();
        @(negedge clk_ir);
        total++; if (res_vld_oh !== 4'b0001) begin bad++; $display("FAIL single_vld got=%b want=0001", res_vld_oh); end
        total++; if (res_q_od !== 32'd7) begin bad++; $display("FAIL single_q got=%0d want=7", res_q_od); end
        total++; if (res_r_od !== 32'd1) begin bad++; $display("FAIL single_r got=%0d want=1", res_r_od); end
        total++; if (res_dz_od !== 1'b0) begin bad++; $display("FAIL single_dz got=%b want=0", res_dz_od); end
        total++; if (busy_od !== 1'b1) begin bad++; $display("FAIL single_busy2 got=%b want=1", busy_od); end
        tick();
        @(negedge clk_ir);
        total++; if (res_vld_oh !== 4'b0000) begin bad++; $display("FAIL single_pulse got=%b want=0000", res_vld_oh); end
        total++; if (busy_od !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy_od); end
        tick();
        set_slot(0, 32'd2, 32'd101);
    endtask

    task automatic test_div_zero();
        // pointer sits at 1 here; request 2 is the only one active
        set_slot(2, 32'd0, 32'h0000_1234);
        req_ih = 4'b0100;
        @(negedge clk_ir);
        total++; if (gnt_oh !== 4'b0100) begin bad++; $display("FAIL dz_gnt got=%b want=0100", gnt_oh); end
        tick();
        req_ih = '0;
        tick();
        tick();
        @(negedge clk_ir);
        total++; if (res_vld_oh !== 4'b0100) begin bad++; $display("FAIL dz_vld got=%b want=0100", res_vld_oh); end
        total++; if (res_q_od !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_q got=%h want=ffffffff", res_q_od); end
        total++; if (res_r_od !== 32'h0000_1234) begin bad++; $display("FAIL dz_r got=%h want=00001234", res_r_od); end
        total++; if (res_dz_od !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", res_dz_od); end
        tick();
        @(negedge clk_ir);
        total++; if (res_vld_oh !== 4'b0000) begin bad++; $display("FAIL dz_pulse got=%b want=0000", res_vld_oh); end
        total++; if (res_q_od !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_hold_q got=%h want=ffffffff", res_q_od); end
        total++; if (res_dz_od !== 1'b1) begin bad++; $display("FAIL dz_hold_flag got=%b want=1", res_dz_od); end
        tick();
        set_slot(2, 32'd4, 32'd121);
    endtask

    logic [N-1:0] fair_req [6] = '{4'b0011, 4'b0011, 4'b1011, 4'b0011, 4'b0011, 4'b0011};
    logic [N-1:0] fair_gnt [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0001};

    task automatic test_fairness();
        // pointer sits at 3 here
        for (int c = 0; c < 6; c++) begin
            req_ih = fair_req[c];
            @(negedge clk_ir);
            total++; if (gnt_oh !== fair_gnt[c]) begin bad++; $display("FAIL fair_gnt c=%0d got=%b want=%b", c, gnt_oh, fair_gnt[c]); end
            tick();
        end
        req_ih = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    logic         en_tab   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] en_gnt   [6] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    logic [N-1:0] en_vld   [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
    logic [W-1:0] en_q     [6] = '{32'd0, 32'd0, 32'd0, 32'd37, 32'd30, 32'd0};
    logic         en_busy  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic test_enable();
        // pointer sits at 1 here
        for (int c = 0; c < 6; c++) begin
            en_ih  = en_tab[c];
            req_ih = 4'b1111;
            @(negedge clk_ir);
            total++; if (gnt_oh !== en_gnt[c]) begin bad++; $display("FAIL en_gnt c=%0d got=%b want=%b", c, gnt_oh, en_gnt[c]); end
            total++; if (res_vld_oh !== en_vld[c]) begin bad++; $display("FAIL en_vld c=%0d got=%b want=%b", c, res_vld_oh, en_vld[c]); end
            if (en_vld[c] != '0) begin
                total++; if (res_q_od !== en_q[c]) begin bad++; $display("FAIL en_q c=%0d got=%0d want=%0d", c, res_q_od, en_q[c]); end
            end
            total++; if (busy_od !== en_busy[c]) begin bad++; $display("FAIL en_busy c=%0d got=%b want=%b", c, busy_od, en_busy[c]); end
            tick();
        end
        req_ih = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_reset_inflight();
        // pointer sits at 0 here
        req_ih = 4'b0011;
        @(negedge clk_ir);
        total++; if (gnt_oh !== 4'b0001) begin bad++; $display("FAIL rif_gnt0 got=%b want=0001", gnt_oh); end
        tick();
        @(negedge clk_ir);
        total++; if (gnt_oh !== 4'b0010) begin bad++; $display("FAIL rif_gnt1 got=%b want=0010", gnt_oh); end
        tick();
        req_ih = '0;
        #1;
        rst_il = 1'b0;
        #1;
        total++; if (div_real_od !== 32'd0) begin bad++; $display("FAIL rif_div_real got=%h want=0", div_real_od); end
        total++; if (div_im_od !== 32'd0) begin bad++; $display("FAIL rif_div_im got=%h want=0", div_im_od); end
        total++; if (res_vld_oh !== 4'b0000) begin bad++; $display("FAIL rif_vld got=%b want=0000", res_vld_oh); end
        total++; if (res_q_od !== 32'd0) begin bad++; $display("FAIL rif_q got=%h want=0", res_q_od); end
        total++; if (res_r_od !== 32'd0) begin bad++; $display("FAIL rif_r got=%h want=0", res_r_od); end
        total++; if (res_dz_od !== 1'b0) begin bad++; $display("FAIL rif_dz got=%b want=0", res_dz_od); end
        total++; if (busy_od !== 1'b0) begin bad++; $display("FAIL rif_busy got=%b want=0", busy_od); end
        tick();
        @(negedge clk_ir);
        rst_il = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_ir);
            total++; if (res_vld_oh !== 4'b0000) begin bad++; $display("FAIL rif_ghost c=%0d got=%b want=0000", c, res_vld_oh); end
            total++; if (busy_od !== 1'b0) begin bad++; $display("FAIL rif_ghost_busy c=%0d got=%b want=0", c, busy_od); end
            tick();
        end
        req_ih = 4'b1100;
        @(negedge clk_ir);
        total++; if (gnt_oh !== 4'b0100) begin bad++; $display("FAIL rif_first got=%b want=0100", gnt_oh); end
        tick();
        req_ih = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_div_zero();
        test_fairness();
        test_enable();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdiv_sched.md
# cdiv_sched

Round-robin scheduler that shares one pipelined complex divider (imaginary/real quotient and remainder) between up to P_NUM_REQ requesters in the fusiform_gyrus datapath. It accepts at most one division per cycle, drives the divider operand bus from registers, and tracks each in-flight operation with a requester tag. Each result is returned to the requester that issued it, with a divide-by-zero flag. It sits between the per-band phase/angle units and the single shared divider instance.

## Interface
- P_DATA_W, 32, operand/result width
- P_NUM_REQ, 4, number of requesters (2..8)
- P_DIV_LAT, 1, divider pipeline latency in cycles (matches divider lpm_pipeline)
- clk_ir  in  1  clock
- rst_il  in  1  asynchronous active-low reset
- en_ih  in  1  grant enable; when low no new grants, in-flight ops still complete
- req_ih  in  P_NUM_REQ  per-requester request, held until granted
- req_real_id  in  P_NUM_REQ*P_DATA_W  packed real parts (denominator), slot i = bits [i*W +: W]
- req_im_id  in  P_NUM_REQ*P_DATA_W  packed imaginary parts (numerator)
- gnt_oh  out  P_NUM_REQ  one-hot combinational grant, request accepted this cycle
- div_real_od  out  P_DATA_W  registered denominator to divider
- div_im_od  out  P_DATA_W  registered numerator to divider
- div_q_id  in  P_DATA_W  divider quotient
- div_r_id  in  P_DATA_W  divider remainder
- res_vld_oh  out  P_NUM_REQ  one-hot result valid, single-cycle pulse
- res_q_od  out  P_DATA_W  result quotient
- res_r_od  out  P_DATA_W  result remainder
- res_dz_od  out  1  result was divide-by-zero (qualified by res_vld_oh)
- busy_od  out  1  any operation in flight

## Operation
- Arbitration: round-robin pointer ptr (0..P_NUM_REQ-1). Grant goes to the first i with req_ih[i]=1, searching ptr, ptr+1, … modulo P_NUM_REQ. gnt_oh = 0 when en_ih=0 or req_ih=0.
- On a grant to i: ptr <= (i+1) mod P_NUM_REQ. Without a grant, ptr holds.
- Operands from slot i are registered into div_real_od/div_im_od at the grant edge. Without a grant, div_* hold their last value.
- Tag pipeline: P_DIV_LAT+1 stages of {vld, idx, dz}. dz = (granted real == 0). Stage 0 loads at the grant edge; a non-grant cycle loads vld=0.
- Output stage: on a last-stage vld, res_vld_oh[idx] <= 1 and res_dz_od <= dz.
  - dz=0: res_q_od <= div_q_id, res_r_od <= div_r_id.
  - dz=1: res_q_od <= all ones, res_r_od <= granted numerator, carried in the tag (divider output ignored).
  - Otherwise res_vld_oh <= 0, and res_q/r/dz hold.
- Requester protocol: keep req_ih[i] high with stable operands until gnt_oh[i]=1 is seen in the same cycle. Deasserting in the next cycle ends the request. Holding it high requests again, and that request is served after the other active requesters (fairness).
- busy_od = OR of all tag-stage vld and the output-stage vld.
- en_ih dropping mid-stream: in-flight ops drain normally; ptr holds.

## Timing
- Grant in cycle t means operands are on div_* in t+1 and the result is on res_* in cycle t+P_DIV_LAT+2 (default t+3).
- Throughput: one grant per cycle. Results return in grant order with no reordering and no backpressure. Requesters must always accept res_vld_oh.
- Reset (asynchronous, any time): ptr=0, all tag vld=0, gnt has no registered state, div_real_od=0, div_im_od=0, res_vld_oh=0, res_q_od=0, res_r_od=0, res_dz_od=0, busy_od=0. In-flight results are discarded and no res_vld pulses for them after reset release.
- Simultaneous grant and result in the same cycle are independent. The pipeline holds P_DIV_LAT+1 ops with no stall.

## Test plan
- Single request: req_ih=4'b0001, real=7, im=50 at t → gnt_oh=0001 at t; res_vld_oh=0001, q=7, r=1, dz=0 at t+3.
- All four requesters held high for 8 cycles with ptr=0 → grants 0,1,2,3,0,1,2,3 on consecutive cycles. Results are back-to-back from t+3, each tagged to the correct index with the correct quotient.
- Divide-by-zero: req 2, real=0, im=0x1234 → res_vld_oh=0100, q=0xFFFFFFFF, r=0x1234, dz=1.
- Fairness: req_ih=0011 continuously, with req 3 asserted midway → req 3 granted within 3 cycles of assertion. No requester granted twice in a row while another is waiting.
- en_ih=0 with req_ih=1111 → gnt_oh=0 and ptr unchanged. Ops issued just before en_ih fell still return, then busy_od falls.
- rst_il pulsed low with 2 ops in flight → all outputs 0 immediately. No res_vld pulse after release; the first post-reset grant goes to the lowest active index.
